// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter, MSB-first, N copies with optional idle gaps.
// Define PARITY_EN to append an even-parity bit after each copy.
module seq_pattern_tx #(
    parameter int   PAT_W    = 3,
    parameter int   CNT_W    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap_cnt,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);
    localparam int IW = $clog2(PAT_W);
    localparam logic [IW-1:0] MSB = IW'(PAT_W - 1);

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, SHIFT, PAR, GAP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SHIFT, GAP, DONE} state_t;
`endif

    state_t state, state_n;
    logic [PAT_W-1:0] pat, pat_n;
    logic [CNT_W-1:0] rep, rep_n, gap_len, gap_n, g, g_n;
    logic [IW-1:0] bit_idx, idx_n;
    logic out_n, vld_n, fs_n, done_n, eoc, nc;

    assign start_ready = state == IDLE;
    assign busy        = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pat         <= '0;
            rep         <= '0;
            gap_len     <= '0;
            g           <= '0;
            bit_idx     <= '0;
            ser_out     <= IDLE_BIT;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            pat         <= pat_n;
            rep         <= rep_n;
            gap_len     <= gap_n;
            g           <= g_n;
            bit_idx     <= idx_n;
            ser_out     <= out_n;
            ser_valid   <= vld_n;
            frame_start <= fs_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        pat_n   = pat;
        rep_n   = rep;
        gap_n   = gap_len;
        g_n     = g;
        idx_n   = bit_idx;
        out_n   = IDLE_BIT;
        vld_n   = 1'b0;
        fs_n    = 1'b0;
        done_n  = 1'b0;
        eoc     = 1'b0;
        nc      = 1'b0;
        case (state)
            IDLE: if (start_valid) begin
                pat_n = pattern;
                rep_n = repeat_cnt;
                gap_n = gap_cnt;
                idx_n = MSB;
                if (repeat_cnt == '0) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    state_n = SHIFT;
                    out_n   = pattern[PAT_W-1];
                    vld_n   = 1'b1;
                    fs_n    = 1'b1;
                end
            end
            SHIFT: if (bit_idx != '0) begin
                idx_n = bit_idx - IW'(1);
                out_n = pat[idx_n];
                vld_n = 1'b1;
            end else begin
`ifdef PARITY_EN
                state_n = PAR;
                out_n   = ^pat;
                vld_n   = 1'b1;
`else
                eoc = 1'b1;
`endif
            end
`ifdef PARITY_EN
            PAR: eoc = 1'b1;
`endif
            GAP: if (g == CNT_W'(1)) nc = 1'b1;
                 else g_n = g - CNT_W'(1);
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // end of a copy: finish the job, chain the next copy, or idle through the gap
        if (eoc) begin
            if (rep == CNT_W'(1)) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else begin
                rep_n = rep - CNT_W'(1);
                if (gap_len == '0) nc = 1'b1;
                else begin
                    state_n = GAP;
                    g_n     = gap_len;
                end
            end
        end
        if (nc) begin
            state_n = SHIFT;
            idx_n   = MSB;
            out_n   = pat[PAT_W-1];
            vld_n   = 1'b1;
            fs_n    = 1'b1;
        end
        if (abort) begin
            state_n = IDLE;
            out_n   = IDLE_BIT;
            vld_n   = 1'b0;
            fs_n    = 1'b0;
            done_n  = 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed-vector bench for seq_pattern_tx.
module tb_seq_pattern_tx;
    localparam int PAT_W = 3;
    localparam int CNT_W = 4;
`ifdef PARITY_EN
    localparam int CW = PAT_W + 1;
`else
    localparam int CW = PAT_W;
`endif

    logic clk = 1'b0, reset = 1'b1, start_valid = 1'b0, abort = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] repeat_cnt = '0, gap_cnt = '0;
    logic start_ready, ser_out, ser_valid, frame_start, busy, done;
    int vectors = 0, miscompares = 0;
    logic [15:0] c_out, c_vld, c_fs, c_done, c_rdy;

    seq_pattern_tx dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .pattern(pattern), .repeat_cnt(repeat_cnt), .gap_cnt(gap_cnt), .abort(abort),
        .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Record n cycles of outputs, oldest cycle in the highest captured bit.
    task automatic cap(input int n);
        c_out = '0; c_vld = '0; c_fs = '0; c_done = '0; c_rdy = '0;
        repeat (n) begin
            @(negedge clk);
            start_valid = 1'b0;
            c_out  = {c_out[14:0], ser_out};
            c_vld  = {c_vld[14:0], ser_valid};
            c_fs   = {c_fs[14:0], frame_start};
            c_done = {c_done[14:0], done};
            c_rdy  = {c_rdy[14:0], start_ready};
        end
    endtask

    task automatic req(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] g);
        pattern = p; repeat_cnt = r; gap_cnt = g; start_valid = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++;
        if ({ser_out, ser_valid, frame_start, done, busy} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want 00000", {ser_out, ser_valid, frame_start, done, busy});
        end
        vectors++;
        if (start_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got %b want 1", start_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        req(3'b101, 4'd2, 4'd0);
        cap(8);
        vectors++;
        if (c_vld[7:0] !== 8'b11111100) begin miscompares++; $display("FAIL b2b_valid got %b want 11111100", c_vld[7:0]); end
        vectors++;
        if (c_out[7:0] !== 8'b10110100) begin miscompares++; $display("FAIL b2b_out got %b want 10110100", c_out[7:0]); end
        vectors++;
        if (c_fs[7:0] !== 8'b10010000) begin miscompares++; $display("FAIL b2b_frame got %b want 10010000", c_fs[7:0]); end
        vectors++;
        if (c_done[7:0] !== 8'b00000010) begin miscompares++; $display("FAIL b2b_done got %b want 00000010", c_done[7:0]); end
    endtask

    task automatic test_gap;
        req(3'b101, 4'd2, 4'd2);
        cap(10);
        vectors++;
        if (c_vld[9:0] !== 10'b1110011100) begin miscompares++; $display("FAIL gap_valid got %b want 1110011100", c_vld[9:0]); end
        vectors++;
        if (c_out[9:0] !== 10'b1010010100) begin miscompares++; $display("FAIL gap_out got %b want 1010010100", c_out[9:0]); end
        vectors++;
        if (c_fs[9:0] !== 10'b1000010000) begin miscompares++; $display("FAIL gap_frame got %b want 1000010000", c_fs[9:0]); end
        vectors++;
        if (c_done[9:0] !== 10'b0000000010) begin miscompares++; $display("FAIL gap_done got %b want 0000000010", c_done[9:0]); end
    endtask

    task automatic test_zero_repeat;
        req(3'b111, 4'd0, 4'd3);
        cap(2);
        vectors++;
        if (c_vld[1:0] !== 2'b00) begin miscompares++; $display("FAIL zero_valid got %b want 00", c_vld[1:0]); end
        vectors++;
        if (c_done[1:0] !== 2'b10) begin miscompares++; $display("FAIL zero_done got %b want 10", c_done[1:0]); end
        vectors++;
        if (c_rdy[1:0] !== 2'b01) begin miscompares++; $display("FAIL zero_ready got %b want 01", c_rdy[1:0]); end
    endtask

    task automatic test_abort;
        req(3'b101, 4'd3, 4'd0);
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if ({ser_valid, busy, done, start_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL abort_state got %b want 0001", {ser_valid, busy, done, start_ready});
        end
        req(3'b110, 4'd1, 4'd0);
        cap(5);
        vectors++;
        if (c_out[4:0] !== 5'b11000 || c_vld[4:0] !== 5'b11100) begin
            miscompares++;
            $display("FAIL abort_restart got out=%b vld=%b want out=11000 vld=11100", c_out[4:0], c_vld[4:0]);
        end
        vectors++;
        if (c_done[4:0] !== 5'b00010) begin miscompares++; $display("FAIL abort_restart_done got %b want 00010", c_done[4:0]); end
        abort = 1'b1;
        req(3'b111, 4'd2, 4'd0);
        @(negedge clk);
        abort = 1'b0;
        start_valid = 1'b0;
        vectors++;
        if ({busy, ser_valid} !== 2'b00) begin miscompares++; $display("FAIL abort_drops_accept got %b want 00", {busy, ser_valid}); end
        cap(2);
        vectors++;
        if (c_done[1:0] !== 2'b00) begin miscompares++; $display("FAIL abort_no_done got %b want 00", c_done[1:0]); end
    endtask

    task automatic test_reset_hold;
        req(3'b101, 4'd2, 4'd0);
        c_out = '0; c_vld = '0; c_fs = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pattern = 3'b010; repeat_cnt = 4'd1;
            c_out = {c_out[14:0], ser_out};
            c_vld = {c_vld[14:0], ser_valid};
            c_fs  = {c_fs[14:0], frame_start};
        end
        vectors++;
        if (c_out[3:0] !== 4'b1011 || c_vld[3:0] !== 4'b1111) begin
            miscompares++;
            $display("FAIL hold_stream got out=%b vld=%b want out=1011 vld=1111", c_out[3:0], c_vld[3:0]);
        end
        vectors++;
        if (c_fs[3:0] !== 4'b1001) begin miscompares++; $display("FAIL hold_frame got %b want 1001", c_fs[3:0]); end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({ser_out, ser_valid, frame_start, done, busy, start_ready} !== 6'b000001) begin
            miscompares++;
            $display("FAIL async_reset got %b want 000001", {ser_out, ser_valid, frame_start, done, busy, start_ready});
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_no_accept got %b want 0", busy); end
        start_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_parity;
`ifdef PARITY_EN
        req(3'b101, 4'd1, 4'd0);
        cap(6);
        vectors++;
        if (c_out[5:0] !== 6'b101000 || c_vld[5:0] !== 6'b111100) begin
            miscompares++;
            $display("FAIL parity_101 got out=%b vld=%b want out=101000 vld=111100", c_out[5:0], c_vld[5:0]);
        end
        vectors++;
        if (c_done[5:0] !== 6'b000010) begin miscompares++; $display("FAIL parity_done got %b want 000010", c_done[5:0]); end
        req(3'b100, 4'd1, 4'd0);
        cap(6);
        vectors++;
        if (c_out[5:0] !== 6'b100100) begin miscompares++; $display("FAIL parity_100 got %b want 100100", c_out[5:0]); end
`endif
    endtask

    task automatic test_max_counts;
        int bits, cyc, bad;
        bits = 0; cyc = 0; bad = 0;
        req(3'b011, 4'd15, 4'd15);
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            start_valid = 1'b0;
            if (ser_valid) bits++;
            else if (ser_out !== 1'b0) bad++;
            if (done) begin
                cyc = i;
                break;
            end
        end
        vectors++;
        if (cyc !== 15 * CW + 14 * 15 + 1) begin miscompares++; $display("FAIL max_done_cycle got %0d want %0d", cyc, 15 * CW + 211); end
        vectors++;
        if (bits !== 15 * CW) begin miscompares++; $display("FAIL max_bits got %0d want %0d", bits, 15 * CW); end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL max_idle_level got %0d bad cycles want 0", bad); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_gap;
        test_zero_repeat;
        test_abort;
        test_reset_hold;
        test_parity;
        test_max_counts;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
